basic_fifo: RTL and testbench

- Synchronous single-clock FIFO: 32 entries x 8 bits, first-word-fall-through read port and an occupancy count output.
- Control is a 3-state FSM (EMPTY / OTHER / FULL) driving a dual-port RAM, with write pointer, read pointer and occupancy counters.
- Sits between a byte producer and a byte consumer; the team's FIFO battery tests drive it through the FIFO interface.

---
 rtl/basic_fifo_pkg.sv | 13 +
 rtl/basic_fifo_ram.sv | 26 ++
 rtl/basic_fifo.sv | 119 +++++++++++
 tb/tb_basic_fifo.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/basic_fifo_pkg.sv
// Shared types and default sizes for the basic_fifo block.
package basic_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    OTHER = 2'b01,
    FULL  = 2'b10
  } fifo_state_t;

endpackage

// File: rtl/basic_fifo_ram.sv
// Dual-port storage for basic_fifo: synchronous write, asynchronous read.
module basic_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clock,
  input  logic                  i_wrEn,
  input  logic [ADDR_WIDTH-1:0] i_wrAddr,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic [ADDR_WIDTH-1:0] i_rdAddr,
  output logic [DATA_WIDTH-1:0] o_rdData
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Contents are never cleared; reset only rewinds the pointers in the parent.
  always_ff @(posedge i_clock) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/basic_fifo.sv
// Single-clock first-word-fall-through FIFO with EMPTY/OTHER/FULL control FSM.
// Define BASIC_FIFO_ERR_FLAGS_EN to add sticky ERR_OVF / ERR_UDF outputs.
module basic_fifo
  import basic_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  CLEAR,
  input  logic                  WRITE,
  input  logic                  READ,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  F_FULL,
  output logic                  F_EMPTY,
`ifdef BASIC_FIFO_ERR_FLAGS_EN
  output logic                  ERR_OVF,
  output logic                  ERR_UDF,
`endif
  output logic [ADDR_WIDTH:0]   USE_DW
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = (ADDR_WIDTH)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_LAST = (ADDR_WIDTH+1)'(DEPTH-1);

  fifo_state_t             r_state;
  fifo_state_t             w_stateNext;
  logic [ADDR_WIDTH-1:0]   r_wrPtr;
  logic [ADDR_WIDTH-1:0]   r_rdPtr;
  logic [ADDR_WIDTH:0]     r_useDw;
  logic                    w_wrOk;
  logic                    w_rdOk;
  logic                    w_flush;
  logic [DATA_WIDTH-1:0]   w_ramData;

  assign w_flush = RESET | CLEAR;
  // A write into a full FIFO is only accepted when a same-cycle read frees a slot.
  assign w_wrOk  = WRITE & ((r_state != FULL) | READ);
  assign w_rdOk  = READ & (r_state != EMPTY);

  basic_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clock  (CLOCK),
    .i_wrEn   (w_wrOk),
    .i_wrAddr (r_wrPtr),
    .i_wrData (DATA_IN),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_ramData)
  );

  always_ff @(posedge CLOCK) begin
    if (w_flush) begin
      r_state <= EMPTY;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_useDw <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_wrOk) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_rdOk) r_rdPtr <= r_rdPtr + PTR_ONE;
      case ({w_wrOk, w_rdOk})
        2'b10:   r_useDw <= r_useDw + CNT_ONE;
        2'b01:   r_useDw <= r_useDw - CNT_ONE;
        default: r_useDw <= r_useDw;
      endcase
    end
  end

  // Transitions only happen on a one-sided operation at the occupancy boundary.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      EMPTY: if (w_wrOk) w_stateNext = OTHER;
      OTHER: begin
        if (w_rdOk && !w_wrOk && (r_useDw == CNT_ONE)) begin
          w_stateNext = EMPTY;
        end else if (w_wrOk && !w_rdOk && (r_useDw == CNT_LAST)) begin
          w_stateNext = FULL;
        end
      end
      FULL:  if (w_rdOk && !w_wrOk) w_stateNext = OTHER;
      default: w_stateNext = EMPTY;
    endcase
  end

  always_comb begin
    F_EMPTY  = (r_state == EMPTY);
    F_FULL   = (r_state == FULL);
    DATA_OUT = (r_state == EMPTY) ? '0 : w_ramData;
  end

  assign USE_DW = r_useDw;

`ifdef BASIC_FIFO_ERR_FLAGS_EN
  logic r_errOvf;
  logic r_errUdf;

  always_ff @(posedge CLOCK) begin
    if (w_flush) begin
      r_errOvf <= 1'b0;
      r_errUdf <= 1'b0;
    end else begin
      if (WRITE && !w_wrOk) r_errOvf <= 1'b1;
      if (READ && (r_state == EMPTY)) r_errUdf <= 1'b1;
    end
  end

  assign ERR_OVF = r_errOvf;
  assign ERR_UDF = r_errUdf;
`endif

endmodule

// File: tb/tb_basic_fifo.sv
// Directed self-checking bench for basic_fifo (default build or BASIC_FIFO_ERR_FLAGS_EN).
module tb_basic_fifo;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       CLEAR = 1'b0;
  logic       WRITE = 1'b0;
  logic       READ  = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic [7:0] DATA_OUT;
  logic       F_FULL;
  logic       F_EMPTY;
  logic [5:0] USE_DW;
`ifdef BASIC_FIFO_ERR_FLAGS_EN
  logic       ERR_OVF;
  logic       ERR_UDF;
`endif

  int testCount = 0;
  int failCount = 0;
  logic [7:0] model [$];

  basic_fifo dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .CLEAR    (CLEAR),
    .WRITE    (WRITE),
    .READ     (READ),
    .DATA_IN  (DATA_IN),
    .DATA_OUT (DATA_OUT),
    .F_FULL   (F_FULL),
    .F_EMPTY  (F_EMPTY),
`ifdef BASIC_FIFO_ERR_FLAGS_EN
    .ERR_OVF  (ERR_OVF),
    .ERR_UDF  (ERR_UDF),
`endif
    .USE_DW   (USE_DW)
  );

  always #5 CLOCK = ~CLOCK;

  // Drive one cycle of inputs, let the edge pass, then return to idle.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] din,
                               input logic clr, input logic rst);
    WRITE   = wr;
    READ    = rd;
    DATA_IN = din;
    CLEAR   = clr;
    RESET   = rst;
    @(posedge CLOCK);
    #1;
    WRITE = 1'b0;
    READ  = 1'b0;
    CLEAR = 1'b0;
    RESET = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkStatus(input string tag, input logic [5:0] expUse,
                             input logic expEmpty, input logic expFull);
    checkOutput({tag, ".use_dw"}, {26'd0, USE_DW}, {26'd0, expUse});
    checkOutput({tag, ".empty"}, {31'd0, F_EMPTY}, {31'd0, expEmpty});
    checkOutput({tag, ".full"}, {31'd0, F_FULL}, {31'd0, expFull});
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkStatus("reset", 6'd0, 1'b1, 1'b0);
    checkOutput("reset.data", {24'd0, DATA_OUT}, 32'h00);

    applyStimulus(1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    checkStatus("wr1", 6'd1, 1'b0, 1'b0);
    checkOutput("wr1.data", {24'd0, DATA_OUT}, 32'h01);

    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checkStatus("rd1", 6'd0, 1'b1, 1'b0);
    checkOutput("rd1.data", {24'd0, DATA_OUT}, 32'h00);

    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checkStatus("rd_empty", 6'd0, 1'b1, 1'b0);
`ifdef BASIC_FIFO_ERR_FLAGS_EN
    checkOutput("rd_empty.udf", {31'd0, ERR_UDF}, 32'd1);
`endif

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkStatus("clear0", 6'd0, 1'b1, 1'b0);
`ifdef BASIC_FIFO_ERR_FLAGS_EN
    checkOutput("clear0.udf", {31'd0, ERR_UDF}, 32'd0);
`endif

    for (int i = 0; i < 31; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0, 1'b0);
    end
    checkStatus("fill31", 6'd31, 1'b0, 1'b0);
    checkOutput("fill31.data", {24'd0, DATA_OUT}, 32'h10);

    applyStimulus(1'b1, 1'b0, 8'h2F, 1'b0, 1'b0);
    checkStatus("fill32", 6'd32, 1'b0, 1'b1);

    applyStimulus(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    checkStatus("ovf33", 6'd32, 1'b0, 1'b1);
    checkOutput("ovf33.data", {24'd0, DATA_OUT}, 32'h10);
`ifdef BASIC_FIFO_ERR_FLAGS_EN
    checkOutput("ovf33.ovf", {31'd0, ERR_OVF}, 32'd1);
`endif

    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checkStatus("full_rd", 6'd31, 1'b0, 1'b0);
    checkOutput("full_rd.data", {24'd0, DATA_OUT}, 32'h11);

    applyStimulus(1'b1, 1'b0, 8'h30, 1'b0, 1'b0);
    checkStatus("refill", 6'd32, 1'b0, 1'b1);

    applyStimulus(1'b1, 1'b1, 8'h31, 1'b0, 1'b0);
    checkStatus("full_rw", 6'd32, 1'b0, 1'b1);
    checkOutput("full_rw.data", {24'd0, DATA_OUT}, 32'h12);

    // Contents now 0x12..0x31 in order; the queue follows them through the wrap.
    for (int i = 0; i < 32; i++) model.push_back(8'h12 + 8'(i));

    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    void'(model.pop_front());
    checkStatus("pre_alt", 6'd31, 1'b0, 1'b0);
    checkOutput("pre_alt.data", {24'd0, DATA_OUT}, {24'd0, model[0]});

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0, 1'b0);
      model.push_back(8'h40 + 8'(i));
      checkOutput("alt_wr.use_dw", {26'd0, USE_DW}, 32'd32);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      void'(model.pop_front());
      checkOutput("alt_rd.use_dw", {26'd0, USE_DW}, 32'd31);
      checkOutput("alt_rd.data", {24'd0, DATA_OUT}, {24'd0, model[0]});
    end
    checkOutput("alt_end.head", {24'd0, DATA_OUT}, 32'h27);

`ifdef BASIC_FIFO_ERR_FLAGS_EN
    checkOutput("sticky.ovf", {31'd0, ERR_OVF}, 32'd1);
`endif

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0, 1'b0);
    end
    checkStatus("fill10", 6'd10, 1'b0, 1'b0);
    checkOutput("fill10.data", {24'd0, DATA_OUT}, 32'hA0);

    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    checkStatus("clear_mid", 6'd0, 1'b1, 1'b0);
    checkOutput("clear_mid.data", {24'd0, DATA_OUT}, 32'h00);
`ifdef BASIC_FIFO_ERR_FLAGS_EN
    checkOutput("clear_mid.ovf", {31'd0, ERR_OVF}, 32'd0);
`endif

    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    checkStatus("empty_rw", 6'd1, 1'b0, 1'b0);
    checkOutput("empty_rw.data", {24'd0, DATA_OUT}, 32'h5A);

    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    checkStatus("reset_mid", 6'd0, 1'b1, 1'b0);
    checkOutput("reset_mid.data", {24'd0, DATA_OUT}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
